// File: rtl/rf_pkg.sv
// Shared widths, ABI register indices and index/data types for the integer register file.
package rf_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 2;
  localparam int unsigned REG_A0   = 10;
  localparam int unsigned REG_A7   = 17;

  typedef logic [XLEN-1:0] xword_t;
  typedef logic [AW-1:0]   ridx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: writes release a register, issue claims mark it busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = rf_pkg::NREGS,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Claim is applied after releases so a younger producer claimed in the
  // same cycle as an older producer's write-back keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned w = 0; w < NWR; w++) begin
      if (wr_en[w]) busy_d[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (claim_en) busy_d[claim_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
    if (reset) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port RV64 integer register file with write-to-read bypass and busy-bit scoreboard.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN   = rf_pkg::XLEN,
  parameter int unsigned NREGS  = rf_pkg::NREGS,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned SP_IDX = REG_SP,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     sp_val,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [NREGS-1:0]    busy_vec,
  output logic [8*XLEN-1:0]   abi_a
);

  localparam int unsigned NABI = REG_A7 - REG_A0 + 1;

  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];
  logic [XLEN-1:0] view   [NREGS];

  // Ascending port order makes the highest-numbered port win on collisions.
  always_comb begin
    for (int unsigned r = 1; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) begin
          regs_d[r] = wr_data[w*XLEN +: XLEN];
        end
      end
      if (reset) regs_d[r] = (r == SP_IDX) ? sp_val : '0;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Stored view with x0 folded in as a constant zero entry.
  always_comb begin
    view[0] = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      view[r] = regs_q[r];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] data;
      logic            hit;
      ra   = rd_addr[p*AW +: AW];
      data = view[ra];
      hit  = 1'b0;
      for (int unsigned w = 0; w < NWR; w++) begin
        if (BYPASS && wr_en[w] && wr_addr[w*AW +: AW] == ra) begin
          data = wr_data[w*XLEN +: XLEN];
          hit  = 1'b1;
        end
      end
      if (ra == '0) begin
        data = '0;
        hit  = 1'b0;
      end
      rd_data[p*XLEN +: XLEN] = data;
      rd_busy[p]              = busy_vec[ra] & ~hit;
    end
  end

  always_comb begin
    abi_a = '0;
    for (int unsigned i = 0; i < NABI; i++) begin
      abi_a[i*XLEN +: XLEN] = view[REG_A0 + i];
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_reg_file_mp;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;

  logic             clk;
  logic             reset;
  logic [XLEN-1:0]  sp_val;
  logic [2*AW-1:0]  rd_addr;
  logic [1:0]       wr_en;
  logic [2*AW-1:0]  wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic             claim_en;
  logic [AW-1:0]    claim_addr;

  logic [2*XLEN-1:0] b_rd_data, n_rd_data;
  logic [1:0]        b_rd_busy, n_rd_busy;
  logic [31:0]       b_busy_vec, n_busy_vec;
  logic [8*XLEN-1:0] b_abi_a, n_abi_a;

  int checks = 0;
  int errors = 0;

  reg_file_mp #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .sp_val(sp_val), .rd_addr(rd_addr),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_vec(b_busy_vec), .abi_a(b_abi_a)
  );

  reg_file_mp #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .reset(reset), .sp_val(sp_val), .rd_addr(rd_addr),
    .rd_data(n_rd_data), .rd_busy(n_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_vec(n_busy_vec), .abi_a(n_abi_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    claim_en = 1'b0;
    claim_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset   = 1'b1;
    sp_val  = 64'h8000_0000;
    rd_addr = '0;
    tick();
    reset = 1'b0;
    rd_addr = {5'd5, 5'd2};
    #1;
    check("rst_sp_b",   b_rd_data[63:0],    64'h8000_0000);
    check("rst_sp_n",   n_rd_data[63:0],    64'h8000_0000);
    check("rst_x5",     b_rd_data[127:64],  64'h0);
    check("rst_busy",   b_busy_vec,         64'h0);
    check("rst_rdbusy", b_rd_busy,          64'h0);

    // Single write, same-cycle bypass vs stored-only
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {64'h0, 64'h1234};
    rd_addr = {5'd0, 5'd5};
    #1;
    check("byp_x5_now",  b_rd_data[63:0], 64'h1234);
    check("nob_x5_now",  n_rd_data[63:0], 64'h0);
    tick(); idle(); #1;
    check("byp_x5_next", b_rd_data[63:0], 64'h1234);
    check("nob_x5_next", n_rd_data[63:0], 64'h1234);
    check("nonbusy_wr",  b_busy_vec,      64'h0);

    // Both ports hit x7: port 1 wins
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {64'hBB, 64'hAA};
    rd_addr = {5'd7, 5'd0};
    #1;
    check("byp_x7_now", b_rd_data[127:64], 64'hBB);
    check("nob_x7_now", n_rd_data[127:64], 64'h0);
    tick(); idle(); #1;
    check("x7_stored_b", b_rd_data[127:64], 64'hBB);
    check("x7_stored_n", n_rd_data[127:64], 64'hBB);

    // x0 write and claim are both ignored
    wr_en = 2'b01; wr_addr = '0; wr_data = {64'h0, 64'hFFFF};
    claim_en = 1'b1; claim_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    check("x0_now", b_rd_data[63:0], 64'h0);
    tick(); idle(); #1;
    check("x0_next",   b_rd_data[63:0], 64'h0);
    check("x0_busy",   b_busy_vec,      64'h0);

    // Claim x9, then release via write-back
    claim_en = 1'b1; claim_addr = 5'd9; rd_addr = {5'd0, 5'd9};
    #1;
    check("claim_same_cycle", b_rd_busy[0], 64'h0);
    tick(); idle(); #1;
    check("x9_busy_b", b_rd_busy[0], 64'h1);
    check("x9_busy_n", n_rd_busy[0], 64'h1);
    check("x9_vec",    b_busy_vec,   64'h200);
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {64'h55, 64'h0};
    #1;
    check("x9_wb_rdbusy_b", b_rd_busy[0],    64'h0);
    check("x9_wb_rdbusy_n", n_rd_busy[0],    64'h1);
    check("x9_wb_data_b",   b_rd_data[63:0], 64'h55);
    tick(); idle(); #1;
    check("x9_released", b_busy_vec,      64'h0);
    check("x9_stored",   n_rd_data[63:0], 64'h55);

    // Claim and write x12 together: claim wins; abi_a is never bypassed
    claim_en = 1'b1; claim_addr = 5'd12;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {64'h0, 64'h77};
    #1;
    check("a2_no_bypass", b_abi_a[2*XLEN +: XLEN], 64'h0);
    tick(); idle(); #1;
    check("x12_busy", b_busy_vec,              64'h1000);
    check("a2_val",   b_abi_a[2*XLEN +: XLEN], 64'h77);
    check("a2_val_n", n_abi_a[2*XLEN +: XLEN], 64'h77);

    // Re-claim of a busy register keeps it busy
    claim_en = 1'b1; claim_addr = 5'd12;
    tick(); idle(); #1;
    check("x12_reclaim", n_busy_vec, 64'h1000);

    // Reset discards same-cycle write and claim
    reset = 1'b1; sp_val = 64'h1000;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {64'h0, 64'hDEAD};
    claim_en = 1'b1; claim_addr = 5'd5;
    tick(); idle(); reset = 1'b0;
    rd_addr = {5'd5, 5'd2};
    #1;
    check("rst2_busy", b_busy_vec,              64'h0);
    check("rst2_a2",   b_abi_a[2*XLEN +: XLEN], 64'h0);
    check("rst2_sp",   b_rd_data[63:0],         64'h1000);
    check("rst2_x5",   n_rd_data[127:64],       64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
